mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Round-robin arbiter that shares the single cache request port between the load/store units of up to four cores. It accepts one outstanding request at a time. It sequences the address/data handshake to the cache and returns a one-cycle grant with read data to the winning requester. A timeout guard keeps a stalled cache from locking up the cores. The block sits between the per-core load/store units and the shared cache controller.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- ADDR_W, 12: address width.
- DATA_W, 8: data width.
- TIMEOUT, 16: maximum cycles spent in ISSUE+WAIT before an error completion; must be ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request.
- req_write  in  NUM_REQ  1 = store, 0 = load.
- req_addr  in  NUM_REQ*ADDR_W  flattened; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  flattened store data, same packing.
- req_gnt  out  NUM_REQ  one-hot completion pulse.
- req_err  out  NUM_REQ  one-hot timeout flag, coincident with req_gnt.
- rsp_rdata  out  DATA_W  load data of the last completion.
- mem_valid  out  1  request to cache.
- mem_write  out  1  latched req_write.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched store data.
- mem_ready  in  1  cache accepts request.
- mem_done  in  1  cache completes access; implies ready.
- mem_rdata  in  DATA_W  valid with mem_done.
- busy  out  1  state ≠ IDLE.
- owner  out  $clog2(NUM_REQ)  index of the current or last served requester.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any req_valid is set, pick the first set bit searching upward from ptr, with wrap-around.
  - Latch id, write, addr and wdata; clear timeout counter; go to ISSUE.
  - mem_done/mem_ready in IDLE are ignored.
- **ISSUE**
  - mem_valid=1; mem_* are driven from the latched fields.
  - mem_done → capture mem_rdata, go to RESP.
  - Else mem_ready → go to WAIT.
  - Else stay in ISSUE.
- **WAIT**
  - mem_valid=0.
  - mem_done → capture mem_rdata, go to RESP.
- **Timeout**
  - The counter increments every cycle in ISSUE/WAIT.
  - When counter == TIMEOUT-1 and mem_done is low: go to RESP with err=1.
  - rsp_rdata is left unchanged on a timeout.
- **RESP**
  - req_gnt[id]=1 for exactly one cycle; req_err[id]=err.
  - ptr ← (id+1) mod NUM_REQ; go to IDLE.
  - For a store, rsp_rdata carries whatever mem_rdata was captured and is don't-care to the requester.
- **Requester rule**
  - Hold req_valid and its fields stable until req_gnt.
  - Deassert req_valid on the edge ending the gnt cycle, unless issuing a new request.
  - Field changes after latching are ignored.
  - A requester dropping req_valid before selection is simply skipped.
- Outputs are Moore-decoded from state and latched registers. There are no combinational paths from req_* to mem_*.

## Timing
- Reset: state=IDLE, ptr=0, counter=0, err=0. All outputs are 0: mem_valid, mem_write, mem_addr, mem_wdata, req_gnt, req_err, rsp_rdata, busy, owner.
- Reset mid-operation abandons the transaction. mem_valid is 0 in the cycle after the rst edge, and no gnt is issued.
- Best-case latency: req_valid sampled in IDLE at cycle 0, mem_valid in cycle 1 with mem_done=1, req_gnt in cycle 2.
- With ready in cycle 1 and done in cycle k, gnt is in cycle k+1.
- Back-to-back: after RESP, the next IDLE arbitration happens one cycle later. Sustained rate is one access per 3 cycles minimum.
- Fairness: a continuously requesting core waits at most NUM_REQ-1 completions.
- Timeout: if neither done nor timeout-on-done occurs, RESP is in cycle TIMEOUT+1 relative to IDLE sampling at cycle 0.
- Simultaneous mem_done and timeout expiry: mem_done wins; err=0.

## Test plan
- Single load: core 2 requests addr 0x1A5; cache asserts ready+done in cycle 1 with rdata 0x3C → mem_addr=0x1A5, req_gnt=4'b0100 in cycle 2, rsp_rdata=0x3C, req_err=0.
- Store with wait: core 0 requests a store of 0x7E to 0x0FF; ready in cycle 1, done in cycle 4 → mem_write=1, mem_wdata=0x7E, mem_valid low from cycle 2, gnt[0] in cycle 5.
- Round-robin: all four cores request continuously with done in the ISSUE cycle → grant order 0,1,2,3,0, one gnt every 3 cycles, owner tracks the order.
- Timeout: core 3 requests; the cache never responds → with TIMEOUT=16, gnt[3]=req_err[3]=1 in cycle 17; rsp_rdata is unchanged; core 0 is served next.
- Reset mid-operation: rst asserted in WAIT → mem_valid, busy and req_gnt are 0 next cycle; the later mem_done is ignored; the next grant goes to the lowest requesting index from ptr=0.
- Dropout and stable hold: core 1 deasserts before selection, so core 2 is chosen. A change to core 2's req_addr during WAIT leaves mem_addr unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one cache request port among NUM_REQ load/store units.
// One request in flight at a time. A timeout guard completes a stalled access with an error.
module mem_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_gnt,
    output logic [NUM_REQ-1:0]          req_err,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        mem_valid,
    output logic                        mem_write,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic                        mem_ready,
    input  logic                        mem_done,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  owner
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     id_q, id_d;
    logic               write_q, write_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    logic               pick_vld;
    logic [IDW-1:0]     pick_id;
    logic [IDW-1:0]     idx;

    // First requester at or above ptr, wrapping around.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDW'((int'(ptr_q) + k) % NUM_REQ);
            if (!pick_vld && req_valid[idx]) begin
                pick_vld = 1'b1;
                pick_id  = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    id_d    = pick_id;
                    write_d = req_write[pick_id];
                    addr_d  = req_addr[int'(pick_id)*ADDR_W +: ADDR_W];
                    wdata_d = req_wdata[int'(pick_id)*DATA_W +: DATA_W];
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE, WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A completion in the expiry cycle still counts as success.
                if (mem_done) begin
                    rdata_d = mem_rdata;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT-1)) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (state_q == ISSUE && mem_ready) begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                ptr_d   = (int'(id_q) == NUM_REQ-1) ? '0 : id_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_valid = (state_q == ISSUE);
    assign mem_write = write_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != IDLE);
    assign owner     = id_q;
    assign rsp_rdata = rdata_q;
    assign req_gnt   = (state_q == RESP) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << id_q) : '0;
    assign req_err   = req_gnt & {NUM_REQ{err_q}};

endmodule
